// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for two initiators on the shared serial system bus.
//   It grants one initiator at a time and muxes that initiator's serial lines
//   onto the shared bus. Between two ownerships it inserts one TURN cycle in
//   which the bus is driven to zero.
//
//   Optional feature: define BUS_ARB_TIMEOUT_EN to build in the hold watchdog.
//   With it, a grant held for MAX_HOLD cycles is preempted, and the preempted
//   initiator is masked until it drops its request. Without it, timeout is 0.
//
// Ports
//   clk, rst_n                      bus clock, async active-low reset
//   m{1,2}_req                      level request, held for the transaction
//   m{1,2}_data_out/_valid/_mode    initiator serial lines
//   m{1,2}_grant                    registered grant (one-hot or zero)
//   bus_data_out/_valid, bus_mode   muxed shared-bus lines (zero when idle)
//   bus_busy                        high while either grant is high
//   timeout                         one-cycle pulse in the TURN after preemption
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_HOLD = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_req,
  input  logic m2_req,
  input  logic m1_data_out,
  input  logic m2_data_out,
  input  logic m1_data_out_valid,
  input  logic m2_data_out_valid,
  input  logic m1_mode,
  input  logic m2_mode,
  output logic m1_grant,
  output logic m2_grant,
  output logic bus_data_out,
  output logic bus_data_out_valid,
  output logic bus_mode,
  output logic bus_busy,
  output logic timeout
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, TURN} state_t;

  state_t state_q, state_d;
  // 1 when the most recent owner was initiator 2; resets to 1 so initiator 1
  // wins the first tie.
  logic   last2_q, last2_d;
  logic   elig1, elig2;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        mask1_q, mask1_d;
  logic        mask2_q, mask2_d;
  logic        timeout_q, timeout_d;
  logic        hold_expired;

  assign hold_expired = (hold_cnt_q == HOLD_LAST);
  assign elig1        = m1_req & ~mask1_q;
  assign elig2        = m2_req & ~mask2_q;
  assign timeout      = timeout_q;
`else
  logic unused_max_hold;

  assign unused_max_hold = ^(32'(MAX_HOLD));
  assign elig1           = m1_req;
  assign elig2           = m2_req;
  assign timeout         = 1'b0;
`endif

  // Arbitration decision shared by IDLE and TURN.
  function automatic state_t pick(input logic e1, input logic e2, input logic last2);
    if (e1 && e2) pick = last2 ? GRANT1 : GRANT2;
    else if (e1)  pick = GRANT1;
    else if (e2)  pick = GRANT2;
    else          pick = IDLE;
  endfunction

  always_comb begin
    state_d = state_q;
    last2_d = last2_q;
`ifdef BUS_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
    // A mask lasts until the request is sampled low.
    mask1_d   = mask1_q & m1_req;
    mask2_d   = mask2_q & m2_req;
    // Counter sits at zero outside grant states, so every grant starts at 0.
    hold_cnt_d = ((state_q == GRANT1) || (state_q == GRANT2)) ? hold_cnt_q + 16'd1 : 16'd0;
`endif
    case (state_q)
      IDLE, TURN: state_d = pick(elig1, elig2, last2_q);
      GRANT1: begin
        if (!m1_req) begin
          state_d = TURN;
          last2_d = 1'b0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d   = TURN;
          last2_d   = 1'b0;
          timeout_d = 1'b1;
          mask1_d   = 1'b1;
        end
`endif
      end
      GRANT2: begin
        if (!m2_req) begin
          state_d = TURN;
          last2_d = 1'b1;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d   = TURN;
          last2_d   = 1'b1;
          timeout_d = 1'b1;
          mask2_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last2_q    <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_q <= 16'd0;
      mask1_q    <= 1'b0;
      mask2_q    <= 1'b0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last2_q    <= last2_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      mask1_q    <= mask1_d;
      mask2_q    <= mask2_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign m1_grant = (state_q == GRANT1);
  assign m2_grant = (state_q == GRANT2);
  assign bus_busy = m1_grant | m2_grant;

  // Zero-latency mux; bus is quiet in IDLE and TURN.
  always_comb begin
    bus_data_out       = 1'b0;
    bus_data_out_valid = 1'b0;
    bus_mode           = 1'b0;
    if (m1_grant) begin
      bus_data_out       = m1_data_out;
      bus_data_out_valid = m1_data_out_valid;
      bus_mode           = m1_mode;
    end else if (m2_grant) begin
      bus_data_out       = m2_data_out;
      bus_data_out_valid = m2_data_out_valid;
      bus_mode           = m2_mode;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter: a vector table for arbitration and muxing,
//   then hand-written sequences for latency, async reset and hold behaviour.
//   Output word order: {m1_grant, m2_grant, bus_busy, bus_data_out,
//   bus_data_out_valid, bus_mode, timeout}.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m1_req = 1'b0, m2_req = 1'b0;
  logic m1_data_out = 1'b0, m2_data_out = 1'b0;
  logic m1_data_out_valid = 1'b0, m2_data_out_valid = 1'b0;
  logic m1_mode = 1'b0, m2_mode = 1'b0;
  logic m1_grant, m2_grant, bus_data_out, bus_data_out_valid, bus_mode;
  logic bus_busy, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m1_req(m1_req), .m2_req(m2_req),
    .m1_data_out(m1_data_out), .m2_data_out(m2_data_out),
    .m1_data_out_valid(m1_data_out_valid), .m2_data_out_valid(m2_data_out_valid),
    .m1_mode(m1_mode), .m2_mode(m2_mode),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .bus_mode(bus_mode), .bus_busy(bus_busy), .timeout(timeout)
  );

  typedef struct packed {
    logic [1:0] req;   // {m1_req, m2_req}
    logic [2:0] l1;    // {data, valid, mode} of initiator 1
    logic [2:0] l2;    // {data, valid, mode} of initiator 2
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] outs();
    return {m1_grant, m2_grant, bus_busy, bus_data_out, bus_data_out_valid, bus_mode, timeout};
  endfunction

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lines(input logic [2:0] l1, input logic [2:0] l2);
    {m1_data_out, m1_data_out_valid, m1_mode} = l1;
    {m2_data_out, m2_data_out_valid, m2_mode} = l2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m1_req = 1'b0;
    m2_req = 1'b0;
    set_lines(3'b000, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Inputs are applied, one clock edge passes, then outputs are compared.
    vecs[0]  = '{2'b00, 3'b000, 3'b000, 7'b0000000}; // idle
    vecs[1]  = '{2'b10, 3'b111, 3'b000, 7'b1011110}; // grant 1, bus = m1
    vecs[2]  = '{2'b10, 3'b010, 3'b111, 7'b1010100};
    vecs[3]  = '{2'b11, 3'b101, 3'b111, 7'b1011010}; // m2 waits
    vecs[4]  = '{2'b01, 3'b111, 3'b111, 7'b0000000}; // turn
    vecs[5]  = '{2'b01, 3'b111, 3'b110, 7'b0111100}; // grant 2, bit 1
    vecs[6]  = '{2'b11, 3'b111, 3'b010, 7'b0110100}; // bit 0, m1 hidden
    vecs[7]  = '{2'b11, 3'b000, 3'b110, 7'b0111100}; // bit 1
    vecs[8]  = '{2'b11, 3'b111, 3'b110, 7'b0111100}; // bit 1
    vecs[9]  = '{2'b10, 3'b111, 3'b111, 7'b0000000}; // turn, bus quiet
    vecs[10] = '{2'b11, 3'b001, 3'b111, 7'b1010010}; // tie -> 1
    vecs[11] = '{2'b01, 3'b111, 3'b000, 7'b0000000}; // turn
    vecs[12] = '{2'b11, 3'b111, 3'b011, 7'b0110110}; // tie -> 2
    vecs[13] = '{2'b10, 3'b111, 3'b111, 7'b0000000}; // turn
    vecs[14] = '{2'b00, 3'b000, 3'b000, 7'b0000000}; // idle
    vecs[15] = '{2'b00, 3'b111, 3'b111, 7'b0000000}; // idle, no leak

    #1;
    chk("reset_state", 7'b0000000);
    do_reset();
    chk("after_reset_release", 7'b0000000);

    for (int i = 0; i < 16; i++) begin
      m1_req = vecs[i].req[1];
      m2_req = vecs[i].req[0];
      set_lines(vecs[i].l1, vecs[i].l2);
      step();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Grant and release latency.
    set_lines(3'b000, 3'b000);
    step();
    m1_req = 1'b1;
    #2;
    chk("grant_not_before_edge", 7'b0000000);
    step();
    chk("grant_after_one_edge", 7'b1010000);
    repeat (5) step();
    chk("grant_held", 7'b1010000);
    m1_req = 1'b0;
    step();
    chk("release_turn", 7'b0000000);
    step();
    chk("release_idle", 7'b0000000);

    // Asynchronous reset in the middle of a grant.
    m1_req = 1'b1;
    set_lines(3'b111, 3'b000);
    step();
    chk("pre_reset_grant1", 7'b1011110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 7'b0000000);
    m1_req = 1'b0;
    m2_req = 1'b1;
    set_lines(3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_no_edge", 7'b0000000);
    step();
    chk("grant2_after_reset", 7'b0110000);
    m2_req = 1'b0;
    step();
    chk("grant2_release", 7'b0000000);

    // Long hold with both initiators requesting.
    do_reset();
    m1_req = 1'b1;
    m2_req = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("hold_g1_%0d", i), 7'b1010000);
    end
    step();
    chk("timeout_turn", 7'b0000001);
    step();
    chk("timeout_then_g2", 7'b0110000);
    step();
    chk("timeout_pulse_ends", 7'b0110000);
    m2_req = 1'b0;
    step();
    chk("g2_release_turn", 7'b0000000);
    step();
    chk("m1_masked_a", 7'b0000000);
    step();
    chk("m1_masked_b", 7'b0000000);
    m1_req = 1'b0;
    step();
    chk("m1_dropped", 7'b0000000);
    m1_req = 1'b1;
    step();
    chk("m1_regranted", 7'b1010000);
`else
    for (int i = 0; i < 120; i++) begin
      step();
      chk($sformatf("hold_g1_%0d", i), 7'b1010000);
    end
    m1_req = 1'b0;
    step();
    chk("hold_release_turn", 7'b0000000);
    step();
    chk("hold_then_g2", 7'b0110000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-initiator arbiter for the dual-initiator serial system bus. It grants exactly one initiator at a time and muxes the granted initiator's serial lines (data bit, valid, mode) onto the shared bus that feeds the address decoder and targets. Arbitration is round-robin. One idle turnaround cycle is inserted between ownerships so the decoder's address shift logic sees a clean gap. An optional hold watchdog forcibly ends an ownership that runs too long.

## Interface
- `MAX_HOLD`, default 256: maximum cycles one grant may be held. Used only when the watchdog is compiled in. Legal range is 2..65535.
- `clk` input 1: bus clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `m1_req`, `m2_req` input 1 each: level request from the initiator; held high for the whole transaction.
- `m1_data_out`, `m2_data_out` input 1 each: initiator serial bit.
- `m1_data_out_valid`, `m2_data_out_valid` input 1 each: initiator bit valid.
- `m1_mode`, `m2_mode` input 1 each: initiator mode; 1 = data, 0 = address.
- `m1_grant`, `m2_grant` output 1 each: registered grant, one-hot or zero.
- `bus_data_out`, `bus_data_out_valid`, `bus_mode` output 1 each: muxed shared-bus lines.
- `bus_busy` output 1: high in any grant state.
- `timeout` output 1: one-cycle pulse on a watchdog preemption.

## Operation
- States: IDLE, GRANT1, GRANT2, TURN.
- `last` register records the most recent owner (1 or 2). Reset value is 2, so initiator 1 wins the first tie.
- **IDLE**:
  - If only one eligible request is present, go to that initiator's GRANT state.
  - If both requests are present, grant the initiator that is not `last`.
  - If no request is present, stay in IDLE.
- **GRANTx**:
  - Stays in GRANTx while `mx_req` = 1.
  - When `mx_req` = 0, go to TURN and set `last` = x.
- **TURN**: lasts exactly one cycle, then applies the IDLE decision rules. It does not pass through IDLE for an extra cycle.
- **Mux**:
  - In GRANTx, the bus outputs are a combinational copy of initiator x's lines.
  - In IDLE and TURN, all three bus outputs are 0.
- **Grants**:
  - `m1_grant` = (state == GRANT1).
  - `m2_grant` = (state == GRANT2).
  - `bus_busy` = `m1_grant` | `m2_grant`.
- **Eligibility**: an initiator is eligible when its request is high and it is not masked. A mask exists only with the watchdog (see Configuration).
- A request arriving in the same cycle another initiator releases its grant waits for TURN to complete.
- **Reset mid-transaction**:
  - All outputs go to 0 immediately (asynchronous).
  - State returns to IDLE, `last` = 2, and masks are cleared.

## Timing
- **Reset values**: `m1_grant`, `m2_grant`, `bus_busy`, `timeout` = 0. `bus_data_out`, `bus_data_out_valid`, `bus_mode` = 0.
- **Grant latency**: request sampled high at edge N in IDLE gives grant high after edge N (one cycle).
- **Release latency**: request sampled low at edge N gives grant low after edge N. TURN occupies cycle N+1. The next grant can be high after edge N+1 at the earliest.
- **Back-to-back ownership** has a minimum of 1 idle bus cycle between owners.
- **Mux**: zero-latency combinational path from initiator lines to bus lines while granted.
- An initiator must not drive `data_out_valid` before it sees its grant. Bits driven while not granted are dropped.

## Configuration
- **`BUS_ARB_TIMEOUT_EN` defined**:
  - A 16-bit hold counter clears on entry to GRANTx and increments each cycle in GRANTx.
  - When the counter reaches `MAX_HOLD`-1 with the request still high, the state goes to TURN, `last` = x, and `timeout` pulses for one cycle (the TURN cycle).
  - The preempted initiator is masked (ineligible) until its request is sampled low. The mask then clears.
- **Not defined**:
  - No counter and no mask logic.
  - `timeout` is tied to 0.
  - A grant is held indefinitely while the request stays high.

## Test plan
- Reset, then `m1_req`=1 at cycle 3 → `m1_grant`=1 from cycle 4. Drop `m1_req` at cycle 10 → grant 0 at cycle 11 (TURN), IDLE at cycle 12.
- After reset, `m1_req`=`m2_req`=1 simultaneously → GRANT1. Drop m1 → one TURN cycle → GRANT2. m1 re-requests during GRANT2 → after m2 drops, TURN then GRANT1 (round-robin alternation over 4 transactions).
- During GRANT2, drive m2 lines with pattern 1,0,1,1 and valid=1, mode=0 → bus lines match cycle-for-cycle. m1 lines toggling during GRANT2 never appear on the bus. Bus lines are 0 during TURN.
- Assert `rst_n`=0 mid-GRANT1 → all outputs 0 in the same cycle, no clock edge needed. After release with m2 requesting → GRANT2 one cycle after the first sampled edge.
- With `BUS_ARB_TIMEOUT_EN`, `MAX_HOLD`=8, m1 holds req high with m2 also requesting → GRANT1 lasts 8 cycles, `timeout` pulses one cycle, then GRANT2. After m2 releases with m1 still high, no grant to m1. m1 drops and re-raises → granted.
- Without the macro, same stimulus → GRANT1 held for 100+ cycles and `timeout` stays 0.
